// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with byte-enabled writes and one-cycle mem_ready after LATENCY cycles.
// Optional MEM_RANGE_CHECK_EN: out-of-range addresses drop writes and read back 32'hDEADBEEF.
module data_mem_responder #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_valid,
   input  logic                  mem_we,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_w_data,
   input  logic [3:0]            mem_byte_en,
   output logic                  mem_ready,
   output logic [DATA_WIDTH-1:0] mem_r_data
);

   localparam int                  DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [3:0]          LAT_M1   = 4'(LATENCY - 1);
   localparam logic [DATA_WIDTH-1:0] OOR_DATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                  state_r;
   logic [3:0]              cnt_r;
   logic                    we_r;
   logic                    oor_r;
   logic [DEPTH_LOG2-1:0]   idx_r;
   logic [DATA_WIDTH-1:0]   w_data_r;
   logic [3:0]              be_r;
   logic [DATA_WIDTH-1:0]   ram_r [DEPTH];

   logic [DEPTH_LOG2-1:0]   idx_s;
   logic                    oor_s;
   logic                    rd_oor_s;
   logic [DATA_WIDTH-1:0]   rd_word_s;
   logic [DATA_WIDTH-1:0]   rd_data_s;
   logic                    unused_addr_s;

   function automatic logic [DATA_WIDTH-1:0] merge_bytes(
      input logic [DATA_WIDTH-1:0] old_word,
      input logic [DATA_WIDTH-1:0] new_word,
      input logic [3:0]            be
   );
      logic [DATA_WIDTH-1:0] result;
      result = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            result[8*i +: 8] = new_word[8*i +: 8];
         end
      end
      return result;
   endfunction

   assign idx_s         = mem_addr[DEPTH_LOG2+1:2];
   assign unused_addr_s = &{1'b0, mem_addr[1:0], mem_addr[ADDR_WIDTH-1:DEPTH_LOG2+2]};

`ifdef MEM_RANGE_CHECK_EN
   assign oor_s = |mem_addr[ADDR_WIDTH-1:DEPTH_LOG2+2];
`else
   assign oor_s = 1'b0;
`endif

   // Read source: live request fields when LATENCY=1 jumps straight from IDLE to RESP.
   always_comb begin
      rd_oor_s  = oor_r;
      rd_word_s = ram_r[idx_r];
      if (state_r == IDLE) begin
         rd_oor_s  = oor_s;
         rd_word_s = ram_r[idx_s];
      end else begin
         rd_oor_s  = oor_r;
         rd_word_s = ram_r[idx_r];
      end
      if (rd_oor_s) begin
         rd_data_s = OOR_DATA;
      end else begin
         rd_data_s = rd_word_s;
      end
   end

   // Commit the latched write on the edge leaving RESP; a reset on that edge aborts it.
   always_ff @(posedge clk) begin
      if (rst && (state_r == RESP) && we_r && !oor_r) begin
         ram_r[idx_r] <= merge_bytes(ram_r[idx_r], w_data_r, be_r);
      end
   end

   // Request FSM: accept, count down, respond with a registered one-cycle ready pulse.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r    <= IDLE;
         cnt_r      <= 4'd0;
         mem_ready  <= 1'b0;
         mem_r_data <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               mem_ready <= 1'b0;
               if (mem_valid) begin
                  we_r     <= mem_we;
                  idx_r    <= idx_s;
                  w_data_r <= mem_w_data;
                  be_r     <= mem_byte_en;
                  oor_r    <= oor_s;
                  cnt_r    <= LAT_M1;
                  if (LAT_M1 != 4'd0) begin
                     state_r <= WAIT;
                  end else begin
                     state_r   <= RESP;
                     mem_ready <= 1'b1;
                     if (!mem_we) begin
                        mem_r_data <= rd_data_s;
                     end
                  end
               end
            end
            WAIT: begin
               cnt_r <= cnt_r - 4'd1;
               if (cnt_r == 4'd1) begin
                  state_r   <= RESP;
                  mem_ready <= 1'b1;
                  if (!we_r) begin
                     mem_r_data <= rd_data_s;
                  end
               end
            end
            RESP: begin
               mem_ready <= 1'b0;
               cnt_r     <= 4'd0;
               state_r   <= IDLE;
            end
            default: begin
               mem_ready <= 1'b0;
               cnt_r     <= 4'd0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: vector table plus hand sequences, scoreboard queue.
module tb_data_mem_responder;

   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_w_data;
   logic [3:0]  mem_byte_en;
   logic        mem_ready;
   logic [31:0] mem_r_data;

   always #5 clk = ~clk;

   data_mem_responder #(.LATENCY(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_valid  (mem_valid),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_w_data (mem_w_data),
      .mem_byte_en(mem_byte_en),
      .mem_ready  (mem_ready),
      .mem_r_data (mem_r_data)
   );

   typedef struct {
      logic        we;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      string       name;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp;
   } vec_t;

   exp_t        sb_q[$];
   vec_t        vecs[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_rd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge of the ready cycle with mem_valid still high.
   task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be, input logic [31:0] exp_rd,
                         input int exp_lat, input bit scramble);
      exp_t e;
      int   k;
      bit   got;
      mem_valid   = 1'b1;
      mem_we      = we;
      mem_addr    = addr;
      mem_w_data  = data;
      mem_byte_en = be;
      e.we   = we;
      e.data = exp_rd;
      sb_q.push_back(e);
      k   = 0;
      got = 1'b0;
      while (!got && k < 64) begin
         @(negedge clk);
         k++;
         if (mem_ready) begin
            got = 1'b1;
         end else if (scramble && k == 1) begin
            mem_addr    = addr ^ 32'h0000_00C0;
            mem_we      = ~we;
            mem_w_data  = ~data;
            mem_byte_en = 4'hF;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: no mem_ready within %0d cycles, expected at %0d", name, k, exp_lat);
         void'(sb_q.pop_front());
      end else begin
         check({name, "_lat"}, 32'(k), 32'(exp_lat));
         e = sb_q.pop_front();
         if (!e.we) begin
            check({name, "_rdata"}, mem_r_data, e.data);
            last_rd = e.data;
         end else begin
            check({name, "_wr_keeps_rdata"}, mem_r_data, last_rd);
         end
      end
   endtask

   task automatic idle(input string name, input int n);
      mem_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check({name, "_ready_low"}, 32'(mem_ready), 32'd0);
      end
   endtask

   initial begin
      rst         = 1'b0;
      mem_valid   = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = 32'd0;
      mem_w_data  = 32'd0;
      mem_byte_en = 4'd0;
      last_rd     = 32'd0;

      vecs.push_back('{"w40",      1'b1, 32'h0000_0040, 32'hCAFE_BABE, 4'hF, 32'h0});
      vecs.push_back('{"r40",      1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'hCAFE_BABE});
      vecs.push_back('{"r43",      1'b0, 32'h0000_0043, 32'h0,         4'h0, 32'hCAFE_BABE});
      vecs.push_back('{"w80",      1'b1, 32'h0000_0080, 32'h1122_3344, 4'hF, 32'h0});
      vecs.push_back('{"w80_be1",  1'b1, 32'h0000_0080, 32'h0000_00AA, 4'h1, 32'h0});
      vecs.push_back('{"r80_a",    1'b0, 32'h0000_0080, 32'h0,         4'h0, 32'h1122_33AA});
      vecs.push_back('{"w80_be3",  1'b1, 32'h0000_0080, 32'h0000_BEEF, 4'h3, 32'h0});
      vecs.push_back('{"r80_b",    1'b0, 32'h0000_0080, 32'h0,         4'h0, 32'h1122_BEEF});
      vecs.push_back('{"w80_be0",  1'b1, 32'h0000_0080, 32'hFFFF_FFFF, 4'h0, 32'h0});
      vecs.push_back('{"r80_c",    1'b0, 32'h0000_0080, 32'h0,         4'h0, 32'h1122_BEEF});
      vecs.push_back('{"w10",      1'b1, 32'h0000_0010, 32'h0123_4567, 4'hF, 32'h0});
      vecs.push_back('{"w04",      1'b1, 32'h0000_0004, 32'h9999_9999, 4'hF, 32'h0});
      vecs.push_back('{"w1004",    1'b1, 32'h0000_1004, 32'h0000_0055, 4'hF, 32'h0});
`ifdef MEM_RANGE_CHECK_EN
      vecs.push_back('{"r1004_oor", 1'b0, 32'h0000_1004, 32'h0,        4'h0, 32'hDEAD_BEEF});
      vecs.push_back('{"r04_kept",  1'b0, 32'h0000_0004, 32'h0,        4'h0, 32'h9999_9999});
`else
      vecs.push_back('{"r04_alias", 1'b0, 32'h0000_0004, 32'h0,        4'h0, 32'h0000_0055});
`endif

      // Reset held for two edges, then ten idle cycles.
      repeat (2) begin
         @(negedge clk);
         check("rst_ready", 32'(mem_ready), 32'd0);
         check("rst_rdata", mem_r_data, 32'd0);
      end
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_ready", 32'(mem_ready), 32'd0);
         check("idle_rdata", mem_r_data, 32'd0);
      end

      for (int i = 0; i < vecs.size(); i++) begin
         do_req(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].exp, LAT, 1'b0);
         idle(vecs[i].name, 1);
      end

      // Back-to-back: valid kept high, next pulse LAT+1 after the previous one; RAW on same word.
      do_req("b2b_a", 1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'hCAFE_BABE, LAT, 1'b0);
      do_req("b2b_b", 1'b0, 32'h0000_0080, 32'h0, 4'h0, 32'h1122_BEEF, LAT + 1, 1'b0);
      do_req("b2b_w", 1'b1, 32'h0000_0200, 32'hA5A5_5A5A, 4'hF, 32'h0, LAT + 1, 1'b0);
      do_req("b2b_raw", 1'b0, 32'h0000_0200, 32'h0, 4'h0, 32'hA5A5_5A5A, LAT + 1, 1'b0);
      idle("b2b", 1);

      // Request fields changed after acceptance must be ignored.
      do_req("scr_rd", 1'b0, 32'h0000_0080, 32'h0, 4'h0, 32'h1122_BEEF, LAT, 1'b1);
      idle("scr_rd", 1);
      do_req("scr_wr", 1'b1, 32'h0000_0300, 32'h1234_5678, 4'hF, 32'h0, LAT, 1'b1);
      idle("scr_wr", 1);
      do_req("scr_chk", 1'b0, 32'h0000_0300, 32'h0, 4'h0, 32'h1234_5678, LAT, 1'b0);
      idle("scr_chk", 1);

      // Reset in WAIT aborts a write: no pulse, old data kept.
      mem_valid   = 1'b1;
      mem_we      = 1'b1;
      mem_addr    = 32'h0000_0010;
      mem_w_data  = 32'hFFFF_FFFF;
      mem_byte_en = 4'hF;
      @(negedge clk);
      rst       = 1'b0;
      mem_valid = 1'b0;
      @(negedge clk);
      check("midrst_ready", 32'(mem_ready), 32'd0);
      rst = 1'b1;
      for (int i = 0; i < LAT + 3; i++) begin
         @(negedge clk);
         check("midrst_no_pulse", 32'(mem_ready), 32'd0);
         check("midrst_rdata", mem_r_data, 32'd0);
      end
      last_rd = 32'd0;
      do_req("midrst_r10", 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h0123_4567, LAT, 1'b0);
      idle("midrst_r10", 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the data-memory request interface driven by the pipeline memory stage: mem_valid, mem_we, mem_addr, mem_w_data, mem_byte_en in; mem_r_data, mem_ready out.
- Holds a word-organised backing RAM and accepts one request at a time.
- Performs byte-enabled writes or whole-word reads, then answers with a one-cycle mem_ready pulse after a programmable latency.
- Used as the backing store behind the cache path and as a standalone slow-memory model for stall testing.

Parameters:
- DATA_WIDTH, 32, data word width; fixed at 32 (4 byte lanes).
- ADDR_WIDTH, 32, byte address width.
- DEPTH_LOG2, 10, log2 of the number of words (default 1024 words = 4 KiB).
- LATENCY, 3, cycles from request acceptance to mem_ready; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- mem_valid  input  1  request present; initiator holds it and all request fields stable until mem_ready.
- mem_we  input  1  1 = write, 0 = read.
- mem_addr  input  ADDR_WIDTH  byte address; bits [1:0] ignored (word access).
- mem_w_data  input  DATA_WIDTH  write data, lane-aligned (byte i on bits 8i+7:8i).
- mem_byte_en  input  4  write lane enables; ignored for reads.
- mem_ready  output  1  one-cycle completion pulse.
- mem_r_data  output  DATA_WIDTH  read word; valid in the mem_ready cycle of a read.

Behaviour:
- Word index = mem_addr[DEPTH_LOG2+1:2].
- States:
  - IDLE: when mem_valid=1, latch we/index/w_data/byte_en, load cnt=LATENCY-1, then go to WAIT if cnt>0, else to RESP.
  - WAIT: decrement cnt each cycle; go to RESP when cnt reaches 0.
  - RESP: perform the access, assert mem_ready=1 for exactly this cycle, return to IDLE.
- Timing: request accepted in cycle N (IDLE and mem_valid=1) gives mem_ready=1 in cycle N+LATENCY. LATENCY=1 gives ready in cycle N+1.
- Reads: mem_r_data is registered. It updates to the stored word on the edge entering RESP, so it is valid during the mem_ready cycle. It holds that value until the next read response.
- Writes:
  - On the edge leaving RESP, each lane i with byte_en[i]=1 is written with latched w_data[8i+7:8i]; other lanes are unchanged.
  - byte_en=4'b0000 completes normally with mem_ready but writes nothing.
  - mem_r_data is not changed by writes.
- Fields are taken from the acceptance-cycle latch only. Input changes during WAIT/RESP are ignored.
- Back-to-back requests: mem_ready is never asserted in IDLE. mem_valid high in the cycle after RESP is a new request, accepted in IDLE that cycle, giving minimum spacing of LATENCY+1 cycles between ready pulses.
- Read-after-write to the same word returns the written data, because the write commits before the next acceptance.
- mem_valid=0 in IDLE: remain in IDLE, mem_ready=0.
- Reset (rst=0 at a clock edge):
  - state=IDLE, cnt=0, mem_ready=0, mem_r_data=0.
  - The RAM array is not reset.
  - Reset during WAIT or RESP aborts the request: no write is committed and no ready pulse is issued.
- Address beyond depth: upper bits ignored, so the access aliases modulo 2^DEPTH_LOG2 words (unless the optional feature is enabled).

Optional Feature:
- Macro: MEM_RANGE_CHECK_EN.
- Defined: a request whose mem_addr[ADDR_WIDTH-1:DEPTH_LOG2+2] is nonzero is out of range.
  - Still completes with normal latency and mem_ready.
  - A write commits nothing.
  - A read returns 32'hDEADBEEF on mem_r_data.
- Not defined: no check; upper address bits are ignored and accesses alias.

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles, release with mem_valid=0 for 10 cycles -> mem_ready=0 and mem_r_data=0 throughout.
- Word write/read, LATENCY=3: write addr 0x40, data 0xCAFEBABE, be=1111 accepted at cycle N -> mem_ready only at N+3. Then read 0x40 -> mem_r_data=0xCAFEBABE in its ready cycle.
- Byte lanes: word 0x80 = 0x11223344; write be=0001 with data 0x000000AA -> read gives 0x112233AA. Then be=0011 with data 0x0000BEEF -> read gives 0x1122BEEF.
- Latency sweep: LATENCY=1 and LATENCY=15 builds, read accepted at cycle N -> ready at N+1 and N+15 respectively. Input address changed during WAIT has no effect on the returned data.
- Reset mid-write: write 0xFFFFFFFF to 0x10 (previously 0x01234567), assert rst in WAIT -> no mem_ready pulse. After release, reading 0x10 returns 0x01234567.
- Aliasing/range with DEPTH_LOG2=10: write 0x55 to 0x1004, then read 0x0004.
  - Without MEM_RANGE_CHECK_EN: read returns 0x00000055.
  - With it: write dropped, read of 0x1004 returns 0xDEADBEEF, and 0x0004 is unchanged.
